// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: segment ordering,
// the active-low hex glyph table and the per-digit shadow payload.
package seg_scan_ctrl_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    // Bit positions inside seg: {g,f,e,d,c,b,a}
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Active-low glyphs for 0-9, A, b, C, d, E, F
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic                en;
        logic                dp;
        logic [NIBBLE_W-1:0] nib;
    } digit_cfg_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decoder
    import seg_scan_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] hex,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = SEG_TABLE[hex];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scan, PWM dimming,
// double-buffered digit data that only changes at a frame boundary.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 131072,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]                presc;
    logic [IDX_W-1:0]                idx;
    logic                            pending;
    digit_cfg_t [NUM_DIGITS-1:0]     shadow;
    digit_cfg_t [NUM_DIGITS-1:0]     staged;

    digit_cfg_t [NUM_DIGITS-1:0]     load_cfg;
    digit_cfg_t                      cur;
    logic                            presc_wrap;
    logic                            frame_wrap;
    logic                            pwm_on;
    logic                            digit_on;
    logic [SEG_W-1:0]                dec_seg;

    // Pack the raw inputs into per-digit payloads
    always_comb begin
        load_cfg = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            load_cfg[i].en  = digit_en[i];
            load_cfg[i].dp  = dp_in[i];
            load_cfg[i].nib = digit_data[4*i +: 4];
        end
    end

    // Slot timing and the on-condition for the currently selected digit
    always_comb begin
        presc_wrap = (presc == PRE_MAX);
        frame_wrap = presc_wrap && (idx == IDX_MAX);
        cur        = shadow[idx];
        pwm_on     = (&brightness) || (presc[PWM_BITS-1:0] < brightness);
        // Prescaler zero is a dark guard cycle so anode switching never ghosts
        digit_on   = cur.en && (presc != '0) && pwm_on;
    end

    seg_hex_decoder u_dec (
        .hex   (cur.nib),
        .seg_c (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            shadow     <= '0;
            staged     <= '0;
            anode      <= '1;
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            presc <= presc_wrap ? '0 : presc + PRE_W'(1);
            if (presc_wrap) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
            end

            // A load on the wrap cycle goes straight to the shadow; otherwise it waits
            if (frame_wrap) begin
                if (load) begin
                    shadow <= load_cfg;
                end else if (pending) begin
                    shadow <= staged;
                end
                pending <= 1'b0;
            end else if (load) begin
                staged  <= load_cfg;
                pending <= 1'b1;
            end

            anode      <= digit_on ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg        <= digit_on ? dec_seg : SEG_OFF;
            dp_n       <= ~(digit_on && cur.dp);
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with 4 digits, 16-cycle slots, 4-bit PWM.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 16;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digit_data;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic [3:0]  brightness;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m = 0;
    bit          model_valid = 1'b0;
    logic [15:0] sh_data, pd_data;
    logic [3:0]  sh_dp, sh_en, pd_dp, pd_en;
    bit          pend;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_ft;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .PWM_BITS    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .brightness (brightness),
        .anode      (anode),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the displayed state is the running cycle count since reset
    always @(posedge clk) begin
        int p, d;
        bit on;
        if (reset) begin
            m = 0;
            sh_data = '0; sh_dp = '0; sh_en = '0; pend = 1'b0;
            pd_data = '0; pd_dp = '0; pd_en = '0;
            exp_anode = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
            model_valid = 1'b1;
        end else begin
            p  = m % RD;
            d  = (m / RD) % ND;
            on = sh_en[d] && (p != 0) && (brightness == 4'hF || p < int'(brightness));
            exp_anode = on ? ~(4'b0001 << d) : 4'hF;
            exp_seg   = on ? hex7(sh_data[4*d +: 4]) : 7'h7F;
            exp_dp    = on ? ~sh_dp[d] : 1'b1;
            exp_ft    = (m % FRAME == FRAME - 1);
            if (m % FRAME == FRAME - 1) begin
                if (load) begin
                    sh_data = digit_data; sh_dp = dp_in; sh_en = digit_en;
                end else if (pend) begin
                    sh_data = pd_data; sh_dp = pd_dp; sh_en = pd_en;
                end
                pend = 1'b0;
            end else if (load) begin
                pd_data = digit_data; pd_dp = dp_in; pd_en = digit_en;
                pend = 1'b1;
            end
            m++;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("anode",      32'(anode),      32'(exp_anode));
            chk("seg",        32'(seg),        32'(exp_seg));
            chk("dp_n",       32'(dp_n),       32'(exp_dp));
            chk("frame_tick", 32'(frame_tick), 32'(exp_ft));
        end
    end

    function automatic int cur_phase();
        return (((m - 1) % FRAME) + FRAME) % FRAME;
    endfunction

    task automatic goto_phase(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cur_phase() != p && n < 200);
        if (cur_phase() != p) chk("goto_phase_timeout", 32'(cur_phase()), 32'(p));
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
        chk({name, "_anode"}, 32'(anode), 32'(a));
        chk({name, "_seg"},   32'(seg),   32'(s));
        chk({name, "_dp_n"},  32'(dp_n),  32'(d));
    endtask

    task automatic count_lit_frame(input string name, input int expected);
        int lows = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (anode != 4'hF) lows++;
        end
        chk(name, 32'(lows), 32'(expected));
    endtask

    initial begin
        int ticks;
        reset = 1'b1; load = 1'b0; digit_data = '0; dp_in = '0; digit_en = '0; brightness = 4'hF;

        @(negedge clk);
        lit("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_frame_tick", 32'(frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle scan: dark, frame tick once per 64 cycles
        goto_phase(62);
        chk("idle_ft_62", 32'(frame_tick), 32'd0);
        goto_phase(63);
        chk("idle_ft_63", 32'(frame_tick), 32'd1);
        ticks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick) ticks++;
        end
        chk("idle_tick_count", 32'(ticks), 32'd2);

        // Full brightness, all digits
        digit_data = 16'h3210; digit_en = 4'hF; dp_in = 4'h0; brightness = 4'hF;
        goto_phase(10);
        pulse_load();
        goto_phase(0);  lit("full_guard0", 4'hF,    7'h7F, 1'b1);
        goto_phase(1);  lit("full_d0",     4'b1110, 7'h40, 1'b1);
        goto_phase(16); lit("full_guard1", 4'hF,    7'h7F, 1'b1);
        goto_phase(17); lit("full_d1",     4'b1101, 7'h79, 1'b1);
        goto_phase(33); lit("full_d2",     4'b1011, 7'h24, 1'b1);
        goto_phase(49); lit("full_d3",     4'b0111, 7'h30, 1'b1);

        // Two loads before the wrap: old frame continues, last load wins
        goto_phase(52);
        digit_data = 16'hABCD;
        pulse_load();
        goto_phase(56);
        digit_data = 16'hEF01;
        pulse_load();
        goto_phase(60); lit("pend_old_d3", 4'b0111, 7'h30, 1'b1);
        goto_phase(1);  lit("lastwin_d0",  4'b1110, 7'h79, 1'b1);
        goto_phase(17); lit("lastwin_d1",  4'b1101, 7'h40, 1'b1);
        goto_phase(33); lit("lastwin_d2",  4'b1011, 7'h0E, 1'b1);
        goto_phase(49); lit("lastwin_d3",  4'b0111, 7'h06, 1'b1);

        // PWM: only digit 1 enabled at brightness 4
        brightness = 4'h4; digit_en = 4'b0010;
        goto_phase(5);
        pulse_load();
        goto_phase(63);
        goto_phase(16); lit("pwm_p0", 4'hF,    7'h7F, 1'b1);
        goto_phase(17); lit("pwm_p1", 4'b1101, 7'h40, 1'b1);
        goto_phase(19); lit("pwm_p3", 4'b1101, 7'h40, 1'b1);
        goto_phase(20); lit("pwm_p4", 4'hF,    7'h7F, 1'b1);
        goto_phase(63);
        count_lit_frame("pwm4_lit_cycles", 3);
        brightness = 4'h0;
        count_lit_frame("pwm0_lit_cycles", 0);

        // Load coincident with the wrap plus decimal points on digits 0 and 2
        brightness = 4'hF; digit_data = 16'h4567; dp_in = 4'b0101; digit_en = 4'hF;
        goto_phase(62);
        pulse_load();
        goto_phase(1);  lit("wrapld_d0", 4'b1110, 7'h78, 1'b0);
        goto_phase(17); lit("wrapld_d1", 4'b1101, 7'h02, 1'b1);
        goto_phase(33); lit("wrapld_d2", 4'b1011, 7'h12, 1'b0);
        goto_phase(49); lit("wrapld_d3", 4'b0111, 7'h19, 1'b1);

        // Reset in slot 2 with a load pending; load during reset is ignored
        goto_phase(20);
        digit_data = 16'h89AB; dp_in = 4'h0;
        pulse_load();
        goto_phase(36);
        reset = 1'b1; load = 1'b1; digit_data = 16'h1111;
        @(negedge clk);
        lit("midreset", 4'hF, 7'h7F, 1'b1);
        chk("midreset_frame_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0; load = 1'b0;
        goto_phase(1);  lit("postreset_d0", 4'hF, 7'h7F, 1'b1);
        goto_phase(17); lit("postreset_d1", 4'hF, 7'h7F, 1'b1);
        goto_phase(63);
        chk("postreset_ft", 32'(frame_tick), 32'd1);
        goto_phase(1);  lit("postreset_next_d0", 4'hF, 7'h7F, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
